count_seq_checker: RTL

Sequence checker that sits on the output of the 4-bit up/down counter and consumes its count stream. Each sample is checked against the expected next value, which depends on the previous value and the MODE used for that step. The block locks onto the stream, flags step errors and wrap-arounds, and keeps a saturating error tally. It is the receiving end of the counter interface, used in-system and as the bench's self-check monitor.

---
 rtl/count_chk_pkg.sv | 15 +
 rtl/count_seq_checker_if.sv | 27 ++
 rtl/sat_counter.sv | 27 ++
 rtl/count_seq_checker.sv | 111 +++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// Shared types and default sizing for the count sequence checker.
// Imported by the interface, the checker top and the bench.
package count_chk_pkg;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    SYNCING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_ERR_W    = 8;
  localparam int DEF_SYNC_LEN = 2;

endpackage

// File: rtl/count_seq_checker_if.sv
// Counter-to-checker link: the counter side drives the sample stream,
// and the checker side returns lock/error status.
interface count_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);

  logic             en;
  logic             mode;
  logic [WIDTH-1:0] cnt;
  logic             locked;
  logic             err;
  logic             wrap;
  logic             dir;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output en, mode, cnt,
    input  locked, err, wrap, dir, err_cnt
  );

  modport slave (
    input  en, mode, cnt,
    output locked, err, wrap, dir, err_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
// Reset is synchronous and active-low.
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [ERR_W-1:0] count
);

  logic [ERR_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + ERR_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/count_seq_checker.sv
// Locks onto an up/down count stream, then flags step errors and wrap steps.
// The step direction for each sample comes from the MODE seen with the previous one.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ERR_W    = DEF_ERR_W,
  parameter int SYNC_LEN = DEF_SYNC_LEN
) (
  input  logic                clk,
  input  logic                rst,
  count_seq_checker_if.slave  bus
);

  localparam int             MW          = $clog2(SYNC_LEN + 1);
  localparam logic [MW-1:0]  SYNC_TARGET = MW'(SYNC_LEN);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] last_cnt_reg;
  logic             last_mode_reg;
  logic [MW-1:0]    match_cnt_reg, match_cnt_next;
  logic [MW-1:0]    match_inc;
  logic             err_reg, err_next;
  logic             wrap_reg, wrap_next;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             at_wrap;
  logic [ERR_W-1:0] err_cnt;

  // Modulo-2^WIDTH prediction falls out of the fixed-width arithmetic.
  assign expected  = last_mode_reg ? (last_cnt_reg + WIDTH'(1)) : (last_cnt_reg - WIDTH'(1));
  assign match     = (bus.cnt == expected);
  assign at_wrap   = last_mode_reg ? (last_cnt_reg == '1) : (last_cnt_reg == '0);
  assign match_inc = match_cnt_reg + MW'(1);

  always_comb begin
    state_next     = state_reg;
    match_cnt_next = match_cnt_reg;
    err_next       = 1'b0;
    wrap_next      = 1'b0;
    if (bus.en) begin
      case (state_reg)
        UNSYNC: begin
          state_next     = SYNCING;
          match_cnt_next = '0;
        end
        SYNCING: begin
          if (match) begin
            match_cnt_next = match_inc;
            if (match_inc == SYNC_TARGET) begin
              state_next = LOCKED;
            end
          end else begin
            match_cnt_next = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            wrap_next = at_wrap;
          end else begin
            // The offending sample is captured and becomes the relock seed.
            err_next       = 1'b1;
            match_cnt_next = '0;
            state_next     = SYNCING;
          end
        end
        default: begin
          state_next     = UNSYNC;
          match_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= UNSYNC;
      last_cnt_reg  <= '0;
      last_mode_reg <= 1'b0;
      match_cnt_reg <= '0;
      err_reg       <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      match_cnt_reg <= match_cnt_next;
      err_reg       <= err_next;
      wrap_reg      <= wrap_next;
      if (bus.en) begin
        last_cnt_reg  <= bus.cnt;
        last_mode_reg <= bus.mode;
      end
    end
  end

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_next),
    .clear (1'b0),
    .count (err_cnt)
  );

  assign bus.locked  = (state_reg == LOCKED);
  assign bus.err     = err_reg;
  assign bus.wrap    = wrap_reg;
  assign bus.dir     = last_mode_reg;
  assign bus.err_cnt = err_cnt;

endmodule
